// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: loads one control word per PE into a local bank over a
// valid/ready stream, then enables the whole PE row for a programmed number of
// cycles and pulses done. Sole driver of PE en and ctrl_signals_in.
module pe_array_sequencer #(
  parameter int NUM_PE  = 4,
  parameter int CTRL_W  = 8,
  parameter int CYCLE_W = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       skip_load,
  input  logic [CYCLE_W-1:0]         run_cycles,
  input  logic                       abort,
  input  logic                       cfg_valid,
  input  logic [CTRL_W-1:0]          cfg_data,
  output logic                       cfg_ready,
  output logic [NUM_PE*CTRL_W-1:0]   ctrl_out,
  output logic [NUM_PE-1:0]          pe_en,
  output logic                       busy,
  output logic                       done
);

  // Index width kept at least 1 bit so a single-PE build still elaborates.
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic [CYCLE_W-1:0] CNT_ONE  = CYCLE_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic [CYCLE_W-1:0] r_cnt;
  logic [CYCLE_W-1:0] w_cnt_next;
  logic               w_wr_en;
  logic [CTRL_W-1:0]  r_bank [NUM_PE];

  // State, word index and run counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state, index, counter and bank-write decode; abort overrides all.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_cnt_next   = r_cnt;
    w_wr_en      = 1'b0;
    if (abort) begin
      w_state_next = S_IDLE;
      w_idx_next   = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_cnt_next = run_cycles;
            if (!skip_load) begin
              w_state_next = S_LOAD;
            end else if (run_cycles != '0) begin
              w_state_next = S_RUN;
            end else begin
              w_state_next = S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (cfg_valid) begin
            w_wr_en = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_idx_next   = '0;
              w_state_next = (r_cnt != '0) ? S_RUN : S_DONE;
            end else begin
              w_idx_next = r_idx + 1'b1;
            end
          end
        end
        S_RUN: begin
          // Leaving at a count of 1 means the counter can never wrap.
          w_cnt_next = r_cnt - 1'b1;
          if (r_cnt == CNT_ONE) begin
            w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          w_state_next = S_IDLE;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end
  end

  // Configuration bank: cleared by reset, written only by accepted LOAD words.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_PE; k++) begin
        r_bank[k] <= '0;
      end
    end else if (w_wr_en) begin
      r_bank[r_idx] <= cfg_data;
    end
  end

  // Each PE's control slice comes straight from its bank entry.
  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_ctrl
      assign ctrl_out[gi*CTRL_W +: CTRL_W] = r_bank[gi];
    end
  endgenerate

  // Status outputs decode from registered state; abort squashes ready so a
  // word presented alongside it is never consumed.
  assign cfg_ready = (r_state == S_LOAD) && !abort;
  assign pe_en     = {NUM_PE{r_state == S_RUN}};
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Scoreboard bench for pe_array_sequencer: stimulus pushes the expected
// completion record (bank, enable count, done cycle); a monitor pops on done.
module tb_pe_array_sequencer;
  localparam int NUM_PE  = 4;
  localparam int CTRL_W  = 8;
  localparam int CYCLE_W = 8;
  localparam int BANK_W  = NUM_PE * CTRL_W;

  logic                 clock = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 start = 1'b0;
  logic                 skip_load = 1'b0;
  logic [CYCLE_W-1:0]   run_cycles = '0;
  logic                 abort = 1'b0;
  logic                 cfg_valid = 1'b0;
  logic [CTRL_W-1:0]    cfg_data = '0;
  logic                 cfg_ready;
  logic [BANK_W-1:0]    ctrl_out;
  logic [NUM_PE-1:0]    pe_en;
  logic                 busy;
  logic                 done;

  pe_array_sequencer #(.NUM_PE(NUM_PE), .CTRL_W(CTRL_W), .CYCLE_W(CYCLE_W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .skip_load(skip_load),
    .run_cycles(run_cycles), .abort(abort), .cfg_valid(cfg_valid),
    .cfg_data(cfg_data), .cfg_ready(cfg_ready), .ctrl_out(ctrl_out),
    .pe_en(pe_en), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [BANK_W-1:0] ctrl;
    int                en_cycles;
    int                done_cyc;
  } exp_t;

  exp_t              sb_q[$];
  logic [CTRL_W-1:0] m_bank [NUM_PE];
  int                compared = 0;
  int                mismatched = 0;
  logic [NUM_PE-1:0] all_en = '1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [BANK_W-1:0] model_bank();
    logic [BANK_W-1:0] v;
    for (int k = 0; k < NUM_PE; k++) v[k*CTRL_W +: CTRL_W] = m_bank[k];
    return v;
  endfunction

  // Monitor: counts enable cycles, watches ctrl stability, pops on done.
  int                en_cnt = 0;
  logic              in_run = 1'b0;
  logic [BANK_W-1:0] run_ctrl = '0;
  exp_t              mon_e;
  always @(negedge clock) begin
    check("pe_en_uniform", 64'(pe_en == '0 || pe_en == all_en), 64'd1);
    if (pe_en == all_en) begin
      if (in_run) check("ctrl_stable_run", ctrl_out, run_ctrl);
      run_ctrl = ctrl_out;
      in_run = 1'b1;
      en_cnt++;
    end else begin
      in_run = 1'b0;
    end
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("done_ctrl", ctrl_out, mon_e.ctrl);
        check("done_en_cycles", 64'(en_cnt), 64'(mon_e.en_cycles));
        check("done_cycle", 64'(cyc), 64'(mon_e.done_cyc));
        check("done_pe_en_low", pe_en, '0);
      end
      en_cnt = 0;
      $display("txn: done at cycle %0d ctrl_out=%h", cyc, ctrl_out);
    end
    if (!busy) en_cnt = 0;
  end

  // Pulse start for one edge; t is the edge index at which it was taken.
  task automatic do_start(input logic skip, input int rc, output int t);
    @(posedge clock); #1;
    start = 1'b1; skip_load = skip; run_cycles = CYCLE_W'(rc);
    @(posedge clock); #1;
    t = cyc;
    start = 1'b0; skip_load = 1'b0; run_cycles = CYCLE_W'($urandom);
  endtask

  // Present words; gap_pct<0 alternates valid 1,0,1,0. abort_after>=0 raises
  // abort with a valid word once that many words have been accepted.
  task automatic load_words(input int gap_pct, input int abort_after,
                            input logic [CTRL_W-1:0] w [NUM_PE], output int last);
    int i = 0;
    int it = 0;
    last = -1;
    while (i < NUM_PE) begin
      if (i == abort_after) begin
        abort = 1'b1; cfg_valid = 1'b1; cfg_data = CTRL_W'($urandom);
        @(posedge clock); #1;
        abort = 1'b0; cfg_valid = 1'b0;
        return;
      end
      if (gap_pct < 0) cfg_valid = (it % 2 == 0);
      else cfg_valid = ($urandom_range(0, 99) >= gap_pct);
      cfg_data = cfg_valid ? w[i] : CTRL_W'($urandom);
      it++;
      @(posedge clock); #1;
      if (cfg_valid) begin
        m_bank[i] = w[i];
        i++;
        last = cyc;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic full_seq(input logic skip, input int rc, input logic [CTRL_W-1:0] w [NUM_PE],
                          input int gap_pct);
    int t;
    int last;
    exp_t e;
    do_start(skip, rc, t);
    if (skip) last = t;
    else load_words(gap_pct, -1, w, last);
    e.ctrl = model_bank();
    e.en_cycles = rc;
    e.done_cyc = last + rc;
    sb_q.push_back(e);
    $display("txn: start edge %0d skip=%0d run=%0d expect done at %0d", t, skip, rc, e.done_cyc);
    for (int k = 0; k < rc + 3; k++) begin
      @(negedge clock);
      check("busy", 64'(busy), 64'(cyc <= e.done_cyc));
      if (skip) check("skip_no_ready", 64'(cfg_ready), 64'd0);
    end
    @(posedge clock); #1;
  endtask

  logic [CTRL_W-1:0] words [NUM_PE];
  int t0;
  int l0;

  initial begin
    for (int k = 0; k < NUM_PE; k++) m_bank[k] = '0;
    // Reset state
    repeat (3) @(negedge clock);
    check("rst_ctrl_out", ctrl_out, '0);
    check("rst_pe_en", pe_en, '0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Fixed words, back-to-back, run of 3
    words = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    full_seq(1'b0, 3, words, 0);
    check("tp1_ctrl", ctrl_out, 64'hD4C3B2A1);

    // Alternating valid
    for (int k = 0; k < NUM_PE; k++) words[k] = CTRL_W'($urandom);
    full_seq(1'b0, 2, words, -1);

    // Rerun existing bank
    full_seq(1'b1, 5, words, 0);

    // Zero-length run with load
    for (int k = 0; k < NUM_PE; k++) words[k] = CTRL_W'($urandom);
    full_seq(1'b0, 0, words, 0);

    // Abort after two words; the word offered with abort must not land
    for (int k = 0; k < NUM_PE; k++) words[k] = CTRL_W'($urandom);
    do_start(1'b0, 4, t0);
    load_words(0, 2, words, l0);
    @(negedge clock);
    check("abort_load_busy", 64'(busy), 64'd0);
    check("abort_load_ready", 64'(cfg_ready), 64'd0);
    check("abort_load_bank", ctrl_out, model_bank());
    repeat (8) @(posedge clock); #1;
    for (int k = 0; k < NUM_PE; k++) words[k] = CTRL_W'($urandom);
    full_seq(1'b0, 4, words, 20);

    // Abort in RUN with an ignored start during RUN
    for (int k = 0; k < NUM_PE; k++) words[k] = CTRL_W'($urandom);
    do_start(1'b0, 10, t0);
    load_words(0, -1, words, l0);
    start = 1'b1; skip_load = 1'b1; run_cycles = 8'd1;
    @(negedge clock);
    check("run_en_on", pe_en, all_en);
    @(posedge clock); #1;
    start = 1'b0; skip_load = 1'b0; abort = 1'b1;
    @(negedge clock);
    check("run_en_still_on", pe_en, all_en);
    @(posedge clock); #1;
    abort = 1'b0;
    @(negedge clock);
    check("abort_run_en", pe_en, '0);
    check("abort_run_busy", 64'(busy), 64'd0);
    check("abort_run_bank", ctrl_out, model_bank());
    repeat (15) @(posedge clock); #1;

    // Asynchronous reset mid-RUN
    do_start(1'b1, 20, t0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < NUM_PE; k++) m_bank[k] = '0;
    check("arst_pe_en", pe_en, '0);
    check("arst_ctrl_out", ctrl_out, '0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_cfg_ready", 64'(cfg_ready), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Randomized sequences
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < NUM_PE; k++) words[k] = CTRL_W'($urandom);
      full_seq(($urandom_range(0, 3) == 0), $urandom_range(0, 12), words, $urandom_range(0, 60));
    end

    // Maximum run length
    full_seq(1'b1, (1 << CYCLE_W) - 1, words, 0);

    repeat (4) @(posedge clock);
    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Absolute time bound so a stuck run still reaches a verdict.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
